// File: rtl/aqalu_arbiter.sv
// aqalu_arbiter: round-robin arbiter sharing one AQALU between two requesters, with optional timed holds.
// Define AQALU_ARB_STATS_EN to add saturating per-requester grant counters.
module aqalu_arbiter #(
  parameter int RESULT_LAT = 2,
  parameter int TICK_DIV   = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [1:0] req0_a,
  input  logic [1:0] req0_b,
  input  logic [1:0] req1_a,
  input  logic [1:0] req1_b,
  input  logic [3:0] req0_op,
  input  logic [3:0] req1_op,
  input  logic [3:0] req0_secs,
  input  logic [3:0] req1_secs,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp0_data,
  output logic [7:0] rsp1_data,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_result,
  output logic       busy
`ifdef AQALU_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;
  state_t r_state, w_next;
  logic r_last;
  logic [19:0] r_cnt, w_wait;
  logic [1:0] r_a, r_b;
  logic [3:0] r_op;
  logic r_rsp0_valid, r_rsp1_valid;
  logic [7:0] r_rsp0_data, r_rsp1_data;
  logic w_gnt, w_hs;
  logic [3:0] w_op, w_secs;
  // r_last holds the most recent grant; resetting it to 1 favours req0 first
  assign w_gnt = (req0_valid && req1_valid) ? !r_last : req1_valid;
  assign req0_ready = reset && r_state == IDLE && req0_valid && !w_gnt;
  assign req1_ready = reset && r_state == IDLE && req1_valid && w_gnt;
  assign w_hs = req0_ready || req1_ready;
  assign w_op = w_gnt ? req1_op : req0_op;
  assign w_secs = w_gnt ? req1_secs : req0_secs;
  // counter counts RUN cycles minus one; RUN exits when it reads zero
  assign w_wait = (w_op == 4'hF && w_secs != 4'd0) ? 20'(w_secs * TICK_DIV - 1) : 20'(RESULT_LAT - 1);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_hs ? RUN : IDLE) :
             r_state == RUN  ? (r_cnt == 20'd0 ? CAPTURE : RUN) : IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
    end else begin
      r_state      <= w_next;
      r_rsp0_valid <= r_state == CAPTURE && !r_last;
      r_rsp1_valid <= r_state == CAPTURE && r_last;
      if (w_hs) begin
        r_last <= w_gnt;
        r_cnt  <= w_wait;
        r_a    <= w_gnt ? req1_a : req0_a;
        r_b    <= w_gnt ? req1_b : req0_b;
        r_op   <= w_op;
      end else if (r_state == RUN && r_cnt != 20'd0) begin
        r_cnt <= r_cnt - 20'd1;
      end
      if (r_state == CAPTURE && !r_last) r_rsp0_data <= alu_result;
      if (r_state == CAPTURE && r_last) r_rsp1_data <= alu_result;
    end
  end
  assign busy       = r_state != IDLE;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_op;
`ifdef AQALU_ARB_STATS_EN
  logic [15:0] r_gc0, r_gc1;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gc0 <= '0;
      r_gc1 <= '0;
    end else begin
      if (req0_ready && r_gc0 != 16'hFFFF) r_gc0 <= r_gc0 + 16'd1;
      if (req1_ready && r_gc1 != 16'hFFFF) r_gc1 <= r_gc1 + 16'd1;
    end
  end
  assign grant_cnt0 = r_gc0;
  assign grant_cnt1 = r_gc1;
`endif
endmodule
